// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-cache port, D-cache port and memory port.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single line-wide memory port.
// Define ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input logic          clk,
    input logic          proc_reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;
    typedef enum logic {GntI, GntD} gnt_e;

    state_e state_q, state_d;
    gnt_e   last_gnt_q, last_gnt_d;

    logic              i_pend, d_pend, d_wins;
    logic              rd, wr, i_rdy, d_rdy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

`ifdef ARB_RR_EN
    // On a tie, the requester that was not served last goes next.
    assign d_wins = d_pend & (~i_pend | (last_gnt_q == GntI));
`else
    assign d_wins = d_pend;
`endif

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= StIdle;
            last_gnt_q <= GntI;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        rd         = 1'b0;
        wr         = 1'b0;
        addr       = '0;
        wdata      = '0;
        i_rdy      = 1'b0;
        d_rdy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_pend || d_pend) begin
                    state_d = d_wins ? StGntD : StGntI;
                end
            end
            StGntI: begin
                // Write dominates a simultaneous read request.
                wr    = bus.i_write;
                rd    = bus.i_read & ~bus.i_write;
                addr  = bus.i_addr;
                wdata = bus.i_write ? bus.i_wdata : '0;
                if (bus.mem_ready) begin
                    i_rdy      = 1'b1;
                    state_d    = StIdle;
                    last_gnt_d = GntI;
                end
            end
            StGntD: begin
                wr    = bus.d_write;
                rd    = bus.d_read & ~bus.d_write;
                addr  = bus.d_addr;
                wdata = bus.d_write ? bus.d_wdata : '0;
                if (bus.mem_ready) begin
                    d_rdy      = 1'b1;
                    state_d    = StIdle;
                    last_gnt_d = GntD;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_read  = rd;
    assign bus.mem_write = wr;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.i_ready   = i_rdy;
    assign bus.d_ready   = d_rdy;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule
